// File: rtl/debug_unit_ctrl.sv
// Host-side debug sequencer: loads instruction memory from UART, runs/steps the MIPS pipeline
// and streams pipeline snapshots back. Optional cycle counter word: DEBUG_UNIT_CYCLE_CNT_EN.
module debug_unit_ctrl #(
  parameter int              LEN            = 32,
  parameter int              NB_ADDR_IM     = 10,
  parameter int              NUM_DUMP_WORDS = 16,
  parameter int              NB_DUMP_SEL    = 5,
  parameter logic [LEN-1:0]  HALT_WORD      = {LEN{1'b1}}
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  input  logic                   i_tx_done,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_start,
  output logic                   o_wea_mem_instr,
  output logic [NB_ADDR_IM-1:0]  o_addr_mem_instr,
  output logic [LEN-1:0]         o_data_mem_instr,
  output logic                   o_mips_enable,
  output logic                   o_mips_rst_n,
  input  logic                   i_flag_halt,
  output logic [NB_DUMP_SEL-1:0] o_dump_sel,
  input  logic [LEN-1:0]         i_dump_word
);

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_CONT = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_NEXT = 8'h4E;
  localparam logic [7:0] CMD_END  = 8'h45;
`ifdef DEBUG_UNIT_CYCLE_CNT_EN
  localparam int TOTAL_WORDS = NUM_DUMP_WORDS + 1;
`else
  localparam int TOTAL_WORDS = NUM_DUMP_WORDS;
`endif
  localparam logic [NB_DUMP_SEL-1:0] LAST_WORD = NB_DUMP_SEL'(TOTAL_WORDS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_RUN, S_STEP_WAIT, S_STEP_EXEC,
    S_DUMP_SEL, S_DUMP_LATCH, S_DUMP_SEND, S_DUMP_WAIT
  } state_t;

  state_t                 state_q, state_d, ret_q, ret_d;
  logic [LEN-1:0]         shift_q, shift_d;
  logic [1:0]             byte_cnt_q, byte_cnt_d;
  logic [NB_ADDR_IM-1:0]  addr_q, addr_d;
  logic                   wea_q, wea_d;
  logic                   mips_rst_n_q, mips_rst_n_d;
  logic                   mips_en_q, mips_en_d;
  logic                   tx_start_q, tx_start_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic [NB_DUMP_SEL-1:0] dump_sel_q, dump_sel_d;
  logic [NB_DUMP_SEL-1:0] word_idx_q, word_idx_d;
`ifdef DEBUG_UNIT_CYCLE_CNT_EN
  logic [31:0]            cyc_cnt_q, cyc_cnt_d;
`endif

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    shift_d      = shift_q;
    byte_cnt_d   = byte_cnt_q;
    addr_d       = addr_q;
    wea_d        = 1'b0;
    mips_rst_n_d = mips_rst_n_q;
    mips_en_d    = mips_en_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    dump_sel_d   = dump_sel_q;
    word_idx_d   = word_idx_q;
`ifdef DEBUG_UNIT_CYCLE_CNT_EN
    cyc_cnt_d    = cyc_cnt_q;
    if (mips_en_q && cyc_cnt_q != 32'hFFFF_FFFF) cyc_cnt_d = cyc_cnt_q + 32'd1;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: begin
              state_d      = S_LOAD;
              mips_rst_n_d = 1'b0;
              addr_d       = '0;
              byte_cnt_d   = '0;
              shift_d      = '0;
`ifdef DEBUG_UNIT_CYCLE_CNT_EN
              cyc_cnt_d    = '0;
`endif
            end
            CMD_CONT: begin
              state_d      = S_RUN;
              mips_rst_n_d = 1'b1;
              mips_en_d    = 1'b1;
            end
            CMD_STEP: begin
              state_d      = S_STEP_WAIT;
              mips_rst_n_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_LOAD: begin
        // wea_q marks the write cycle; the address advances right after it
        if (wea_q) begin
          addr_d = addr_q + NB_ADDR_IM'(1);
          if (shift_q == HALT_WORD) state_d = S_IDLE;
        end
        if (i_rx_valid && !(wea_q && shift_q == HALT_WORD)) begin
          shift_d    = {shift_q[LEN-9:0], i_rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) wea_d = 1'b1;
        end
      end
      S_RUN: begin
        mips_en_d = 1'b1;
        if (i_flag_halt) begin
          mips_en_d  = 1'b0;
          ret_d      = S_IDLE;
          word_idx_d = '0;
          state_d    = S_DUMP_SEL;
        end
      end
      S_STEP_WAIT: begin
        mips_en_d = 1'b0;
        if (i_rx_valid) begin
          if (i_rx_data == CMD_NEXT) begin
            state_d   = S_STEP_EXEC;
            mips_en_d = 1'b1;
          end else if (i_rx_data == CMD_END) begin
            state_d = S_IDLE;
          end
        end
      end
      S_STEP_EXEC: begin
        mips_en_d  = 1'b0;
        ret_d      = i_flag_halt ? S_IDLE : S_STEP_WAIT;
        word_idx_d = '0;
        state_d    = S_DUMP_SEL;
      end
      S_DUMP_SEL: begin
        dump_sel_d = word_idx_q;
        state_d    = S_DUMP_LATCH;
      end
      S_DUMP_LATCH: begin
        shift_d = i_dump_word;
`ifdef DEBUG_UNIT_CYCLE_CNT_EN
        if (word_idx_q == LAST_WORD) shift_d = LEN'(cyc_cnt_q);
`endif
        byte_cnt_d = '0;
        state_d    = S_DUMP_SEND;
      end
      S_DUMP_SEND: begin
        tx_start_d = 1'b1;
        tx_data_d  = shift_q[LEN-1:LEN-8];
        shift_d    = {shift_q[LEN-9:0], 8'h00};
        state_d    = S_DUMP_WAIT;
      end
      S_DUMP_WAIT: begin
        if (i_tx_done) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q != 2'd3) begin
            state_d = S_DUMP_SEND;
          end else if (word_idx_q == LAST_WORD) begin
            state_d    = ret_q;
            dump_sel_d = '0;
          end else begin
            word_idx_d = word_idx_q + NB_DUMP_SEL'(1);
            state_d    = S_DUMP_SEL;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q      <= S_IDLE;
      ret_q        <= S_IDLE;
      shift_q      <= '0;
      byte_cnt_q   <= '0;
      addr_q       <= '0;
      wea_q        <= 1'b0;
      mips_rst_n_q <= 1'b0;
      mips_en_q    <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      dump_sel_q   <= '0;
      word_idx_q   <= '0;
`ifdef DEBUG_UNIT_CYCLE_CNT_EN
      cyc_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      shift_q      <= shift_d;
      byte_cnt_q   <= byte_cnt_d;
      addr_q       <= addr_d;
      wea_q        <= wea_d;
      mips_rst_n_q <= mips_rst_n_d;
      mips_en_q    <= mips_en_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      dump_sel_q   <= dump_sel_d;
      word_idx_q   <= word_idx_d;
`ifdef DEBUG_UNIT_CYCLE_CNT_EN
      cyc_cnt_q    <= cyc_cnt_d;
`endif
    end
  end

  assign o_tx_data        = tx_data_q;
  assign o_tx_start       = tx_start_q;
  assign o_wea_mem_instr  = wea_q;
  assign o_addr_mem_instr = addr_q;
  assign o_data_mem_instr = shift_q;
  assign o_mips_enable    = mips_en_q;
  assign o_mips_rst_n     = mips_rst_n_q;
  assign o_dump_sel       = dump_sel_q;

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Scoreboard bench for debug_unit_ctrl: directed UART command sequences, with expected memory
// writes and tx bytes queued at stimulus time and checked by an independent monitor.
module tb_debug_unit_ctrl;
  localparam int LEN = 32;
  localparam int NB_ADDR_IM = 10;
  localparam int NB_DUMP_SEL = 5;

  logic                   i_clk = 1'b0;
  logic                   i_rst = 1'b0;
  logic [7:0]             i_rx_data = '0;
  logic                   i_rx_valid = 1'b0;
  logic                   i_tx_done = 1'b0;
  logic [7:0]             o_tx_data;
  logic                   o_tx_start;
  logic                   o_wea_mem_instr;
  logic [NB_ADDR_IM-1:0]  o_addr_mem_instr;
  logic [LEN-1:0]         o_data_mem_instr;
  logic                   o_mips_enable;
  logic                   o_mips_rst_n;
  logic                   i_flag_halt = 1'b0;
  logic [NB_DUMP_SEL-1:0] o_dump_sel;
  logic [LEN-1:0]         i_dump_word;

  debug_unit_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .i_tx_done(i_tx_done), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
    .o_wea_mem_instr(o_wea_mem_instr), .o_addr_mem_instr(o_addr_mem_instr),
    .o_data_mem_instr(o_data_mem_instr), .o_mips_enable(o_mips_enable),
    .o_mips_rst_n(o_mips_rst_n), .i_flag_halt(i_flag_halt), .o_dump_sel(o_dump_sel),
    .i_dump_word(i_dump_word)
  );

  always #5 i_clk = ~i_clk;
  assign i_dump_word = 32'hA000_0000 + 32'(o_dump_sel);

  int n_tests = 0;
  int n_fail = 0;
  int en_cycles = 0;
  int tx_pulses = 0;
  int wr_pulses = 0;
  int tx_wait = 0;
  bit tx_busy = 1'b0;
  logic [NB_ADDR_IM+LEN-1:0] exp_wr_q[$];
  logic [7:0]                exp_tx_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("[TB] ok %s: %h", name, act);
    end
  endtask

  // Monitor plus a simple UART tx model answering each start with a delayed done pulse
  always @(negedge i_clk) begin
    logic [NB_ADDR_IM+LEN-1:0] w;
    logic [7:0] b;
    if (i_tx_done) begin
      i_tx_done = 1'b0;
      tx_busy   = 1'b0;
    end else if (tx_busy) begin
      if (tx_wait == 0) i_tx_done = 1'b1;
      else tx_wait--;
    end
    if (o_mips_enable) en_cycles++;
    if (o_wea_mem_instr) begin
      wr_pulses++;
      if (exp_wr_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("[TB] FAIL unexpected_write: addr %h data %h, expected none", o_addr_mem_instr, o_data_mem_instr);
      end else begin
        w = exp_wr_q.pop_front();
        check("mem_write", 64'({o_addr_mem_instr, o_data_mem_instr}), 64'(w));
      end
    end
    if (o_tx_start) begin
      tx_pulses++;
      check("tx_start_after_done", 64'(tx_busy), 64'd0);
      tx_busy = 1'b1;
      tx_wait = 3;
      if (exp_tx_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("[TB] FAIL unexpected_tx: byte %h, expected none", o_tx_data);
      end else begin
        b = exp_tx_q.pop_front();
        check("tx_byte", 64'(o_tx_data), 64'(b));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge i_clk);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8]);
      idle(3);
    end
  endtask

  task automatic push_wr(input int a, input logic [31:0] d);
    exp_wr_q.push_back({NB_ADDR_IM'(a), d});
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_tx_q.push_back(w[i*8 +: 8]);
  endtask

  task automatic push_dump(input logic [31:0] cyc);
    for (int k = 0; k < 16; k++) push_word(32'(32'hA000_0000 + k));
`ifdef DEBUG_UNIT_CYCLE_CNT_EN
    push_word(cyc);
`else
    if (cyc == 32'hFFFF_FFFF) $display("[TB] note: cycle word unused");
`endif
  endtask

  task automatic wait_drain(input string name, input int budget);
    int t = 0;
    while ((exp_tx_q.size() != 0 || exp_wr_q.size() != 0 || tx_busy) && t < budget) begin
      @(negedge i_clk);
      t++;
    end
    n_tests++;
    if (t >= budget) begin
      n_fail++;
      $display("[TB] FAIL %s_timeout: %0d tx and %0d writes still pending, expected 0", name, exp_tx_q.size(), exp_wr_q.size());
    end else begin
      $display("[TB] ok %s drained in %0d cycles", name, t);
    end
    idle(4);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rst_n"},    64'(o_mips_rst_n), 64'd0);
    check({tag, "_enable"},   64'(o_mips_enable), 64'd0);
    check({tag, "_wea"},      64'(o_wea_mem_instr), 64'd0);
    check({tag, "_tx_start"}, 64'(o_tx_start), 64'd0);
    check({tag, "_dump_sel"}, 64'(o_dump_sel), 64'd0);
    check({tag, "_addr"},     64'(o_addr_mem_instr), 64'd0);
  endtask

  localparam int DUMP_BYTES =
`ifdef DEBUG_UNIT_CYCLE_CNT_EN
    68;
`else
    64;
`endif

  initial begin
    int en0, tx0, wr0;
    i_rst = 1'b0;
    idle(3);
    i_rst = 1'b1;
    idle(1);
    check_reset_outputs("reset");

    // Junk byte and a stray 'N' in IDLE change nothing
    send_byte(8'h99);
    idle(3);
    send_byte(8'h4E);
    idle(10);
    check_reset_outputs("idle_junk");
    check("idle_junk_tx_count", 64'(tx_pulses), 64'd0);

    // Load three words, the last being the halt word
    wr0 = wr_pulses;
    push_wr(0, 32'h0000_0001);
    push_wr(1, 32'h1234_5678);
    push_wr(2, 32'hFFFF_FFFF);
    send_byte(8'h4C);
    idle(3);
    send_word(32'h0000_0001);
    send_word(32'h1234_5678);
    send_word(32'hFFFF_FFFF);
    wait_drain("load", 200);
    check("load_write_count", 64'(wr_pulses - wr0), 64'd3);
    check("load_rst_n", 64'(o_mips_rst_n), 64'd0);

    // Continuous run: 20 enable cycles with halt low, then the halt cycle
    en0 = en_cycles; tx0 = tx_pulses;
    push_dump(32'd21);
    send_byte(8'h43);
    check("run_rst_n", 64'(o_mips_rst_n), 64'd1);
    check("run_enable", 64'(o_mips_enable), 64'd1);
    repeat (20) @(negedge i_clk);
    i_flag_halt = 1'b1;
    @(negedge i_clk);
    i_flag_halt = 1'b0;
    check("run_enable_after_halt", 64'(o_mips_enable), 64'd0);
    wait_drain("run_dump", 3000);
    check("run_enable_cycles", 64'(en_cycles - en0), 64'd21);
    check("run_tx_count", 64'(tx_pulses - tx0), 64'(DUMP_BYTES));
    check("run_dump_sel_back", 64'(o_dump_sel), 64'd0);

    // Single step twice, then leave with 'E'
    send_byte(8'h53);
    idle(3);
    for (int s = 0; s < 2; s++) begin
      en0 = en_cycles; tx0 = tx_pulses;
      push_dump(32'(22 + s));
      send_byte(8'h4E);
      wait_drain("step_dump", 3000);
      check("step_enable_cycles", 64'(en_cycles - en0), 64'd1);
      check("step_tx_count", 64'(tx_pulses - tx0), 64'(DUMP_BYTES));
    end
    tx0 = tx_pulses;
    send_byte(8'h45);
    idle(20);
    check("step_end_no_tx", 64'(tx_pulses - tx0), 64'd0);

    // Step that hits halt returns to IDLE, so a later 'N' is ignored
    send_byte(8'h53);
    idle(3);
    en0 = en_cycles; tx0 = tx_pulses;
    push_dump(32'd24);
    send_byte(8'h4E);
    i_flag_halt = 1'b1;
    @(negedge i_clk);
    i_flag_halt = 1'b0;
    wait_drain("halt_step_dump", 3000);
    check("halt_step_enable_cycles", 64'(en_cycles - en0), 64'd1);
    check("halt_step_tx_count", 64'(tx_pulses - tx0), 64'(DUMP_BYTES));
    tx0 = tx_pulses;
    send_byte(8'h4E);
    idle(30);
    check("after_halt_n_ignored_tx", 64'(tx_pulses - tx0), 64'd0);
    check("after_halt_n_ignored_en", 64'(en_cycles - en0), 64'd1);

    // Reset in the middle of a word drops it; reload starts clean at address 0
    wr0 = wr_pulses;
    send_byte(8'h4C);
    idle(3);
    send_byte(8'h11);
    idle(3);
    send_byte(8'h22);
    idle(2);
    i_rst = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    idle(2);
    check_reset_outputs("mid_reset");
    push_wr(0, 32'hAABB_CCDD);
    push_wr(1, 32'hFFFF_FFFF);
    send_byte(8'h4C);
    idle(3);
    send_word(32'hAABB_CCDD);
    send_word(32'hFFFF_FFFF);
    wait_drain("reload", 200);
    check("reload_write_count", 64'(wr_pulses - wr0), 64'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end
endmodule
